// File: rtl/sprite_pixel_arbiter_if.sv
// Pixel-side bundle for sprite_pixel_arbiter: layer indices, hit pulses and
// the arbitrated colour index with its flash status.
interface sprite_pixel_arbiter_if;
    logic       pix_valid;
    logic       blank;
    logic       frame_start;
    logic [3:0] bg_idx;
    logic [3:0] a_idx;
    logic [3:0] b_idx;
    logic       a_hit;
    logic       b_hit;
    logic [3:0] color_index;
    logic       is_b;
    logic       out_valid;
    logic [1:0] layer_sel;
    logic       a_flash;
    logic       b_flash;

    modport master (
        output pix_valid, blank, frame_start, bg_idx, a_idx, b_idx, a_hit, b_hit,
        input  color_index, is_b, out_valid, layer_sel, a_flash, b_flash
    );

    modport slave (
        input  pix_valid, blank, frame_start, bg_idx, a_idx, b_idx, a_hit, b_hit,
        output color_index, is_b, out_valid, layer_sel, a_flash, b_flash
    );
endinterface

// File: rtl/sprite_pixel_arbiter.sv
// Per-pixel layer arbiter (bg / player A / player B) with per-player hit-flash
// FSMs that blink a hit sprite white; two-stage registered pipeline.
module sprite_pixel_arbiter #(
    parameter int unsigned FLASH_FRAMES = 30,
    parameter int unsigned BLINK_PERIOD = 4,
    parameter int unsigned WHITE_IDX    = 8,
    parameter int unsigned BG_FILL_IDX  = 0,
    parameter int unsigned B_ON_TOP     = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    sprite_pixel_arbiter_if.slave bus
);
    localparam int REM_W = $clog2(FLASH_FRAMES + 1);
    localparam int BLK_W = $clog2(BLINK_PERIOD + 1);

    typedef enum logic {IDLE = 1'b0, FLASH = 1'b1} flash_state_t;

    typedef struct packed {
        logic [3:0] idx;
        logic       is_b;
        logic [1:0] sel;
    } arb_t;

    flash_state_t     flash_state [2];
    logic [REM_W-1:0] rem         [2];
    logic [BLK_W-1:0] blink       [2];
    logic [1:0]       white;
    logic [1:0]       flash;
    logic [1:0]       hit;

    logic [3:0] bg_p1, a_p1, b_p1;
    logic       blank_p1, vld_p1;
    logic [1:0] white_p1;

    logic [3:0] color_index_p2;
    logic       is_b_p2, vld_p2;
    logic [1:0] layer_sel_p2;
    arb_t       arb;

    assign hit = {bus.b_hit, bus.a_hit};

    // A hit always reloads, even when it coincides with frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                flash_state[p] <= IDLE;
                rem[p]         <= '0;
                blink[p]       <= '0;
                white[p]       <= 1'b0;
                flash[p]       <= 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (hit[p]) begin
                    flash_state[p] <= FLASH;
                    rem[p]         <= REM_W'(FLASH_FRAMES);
                    blink[p]       <= '0;
                    white[p]       <= 1'b1;
                    flash[p]       <= 1'b1;
                end else if (flash_state[p] == FLASH && bus.frame_start) begin
                    if (rem[p] == REM_W'(1)) begin
                        flash_state[p] <= IDLE;
                        rem[p]         <= '0;
                        blink[p]       <= '0;
                        white[p]       <= 1'b0;
                        flash[p]       <= 1'b0;
                    end else begin
                        rem[p] <= rem[p] - REM_W'(1);
                        if (blink[p] == BLK_W'(BLINK_PERIOD - 1)) begin
                            blink[p] <= '0;
                            white[p] <= ~white[p];
                        end else begin
                            blink[p] <= blink[p] + BLK_W'(1);
                        end
                    end
                end
            end
        end
    end

    function automatic arb_t arbitrate(
        input logic       blank_in,
        input logic [3:0] bg,
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       white_a,
        input logic       white_b
    );
        arb_t r;
        logic take_b, take_a;
        r      = '0;
        take_b = (b != 4'd0) && ((B_ON_TOP != 0) || (a == 4'd0));
        take_a = (a != 4'd0) && !take_b;
        if (!blank_in) begin
            if (take_b) begin
                r.sel  = 2'd3;
                r.idx  = white_b ? 4'(WHITE_IDX) : b;
                r.is_b = !white_b;
            end else if (take_a) begin
                r.sel = 2'd2;
                r.idx = white_a ? 4'(WHITE_IDX) : a;
            end else if (bg != 4'd0) begin
                r.sel = 2'd1;
                r.idx = bg;
            end else begin
                r.sel = 2'd0;
                r.idx = 4'(BG_FILL_IDX);
            end
        end
        return r;
    endfunction

    // Stage 1: capture the pixel together with the white flags current for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bg_p1    <= '0;
            a_p1     <= '0;
            b_p1     <= '0;
            blank_p1 <= 1'b0;
            vld_p1   <= 1'b0;
            white_p1 <= '0;
        end else begin
            bg_p1    <= bus.bg_idx;
            a_p1     <= bus.a_idx;
            b_p1     <= bus.b_idx;
            blank_p1 <= bus.blank;
            vld_p1   <= bus.pix_valid;
            white_p1 <= white;
        end
    end

    assign arb = arbitrate(blank_p1, bg_p1, a_p1, b_p1, white_p1[0], white_p1[1]);

    // Stage 2: register the arbitration result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_index_p2 <= '0;
            is_b_p2        <= 1'b0;
            layer_sel_p2   <= '0;
            vld_p2         <= 1'b0;
        end else begin
            color_index_p2 <= arb.idx;
            is_b_p2        <= arb.is_b;
            layer_sel_p2   <= arb.sel;
            vld_p2         <= vld_p1;
        end
    end

    assign bus.color_index = color_index_p2;
    assign bus.is_b        = is_b_p2;
    assign bus.layer_sel   = layer_sel_p2;
    assign bus.out_valid   = vld_p2;
    assign bus.a_flash     = flash[0];
    assign bus.b_flash     = flash[1];
endmodule

// File: tb/tb_sprite_pixel_arbiter.sv
// Randomised and directed bench for sprite_pixel_arbiter against a frame-count
// based reference model.
module tb_sprite_pixel_arbiter;
    localparam int FF   = 30;
    localparam int BP   = 4;
    localparam int WI   = 8;
    localparam int FILL = 0;

    typedef struct packed {
        logic       v;
        logic [3:0] idx;
        logic       isb;
        logic [1:0] sel;
        logic       af;
        logic       bf;
    } obs_t;

    typedef struct packed {
        logic       pv;
        logic       blank;
        logic       fs;
        logic [3:0] bg;
        logic [3:0] a;
        logic [3:0] b;
        logic       ah;
        logic       bh;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sprite_pixel_arbiter_if bus ();

    sprite_pixel_arbiter #(
        .FLASH_FRAMES(FF), .BLINK_PERIOD(BP), .WHITE_IDX(WI),
        .BG_FILL_IDX(FILL), .B_ON_TOP(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int   n_checks = 0;
    int   n_fails  = 0;
    obs_t pipe [2];
    bit   act [2];
    int   frames [2];

    // White iff the player is flashing and an even number of blink half-phases elapsed.
    function automatic bit white_of(int p);
        return act[p] && (((frames[p] / BP) % 2) == 0);
    endfunction

    function automatic obs_t model_arb(stim_t s, bit wa, bit wb);
        obs_t       r;
        logic [3:0] lay [3];
        logic [1:0] code [3];
        bit         found;
        r       = '0;
        r.v     = s.pv;
        lay[0]  = s.b;  code[0] = 2'd3;
        lay[1]  = s.a;  code[1] = 2'd2;
        lay[2]  = s.bg; code[2] = 2'd1;
        found   = 0;
        if (!s.blank) begin
            for (int i = 0; i < 3; i++) begin
                if (!found && lay[i] != 4'd0) begin
                    found = 1;
                    r.sel = code[i];
                    r.idx = lay[i];
                end
            end
            if (!found) r.idx = 4'(FILL);
            if (r.sel == 2'd2 && wa) r.idx = 4'(WI);
            if (r.sel == 2'd3) begin
                if (wb) r.idx = 4'(WI);
                else    r.isb = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic stim_t idle_stim();
        return '0;
    endfunction

    function automatic stim_t pix(logic [3:0] bg, logic [3:0] a, logic [3:0] b);
        stim_t s;
        s    = '0;
        s.pv = 1'b1;
        s.bg = bg;
        s.a  = a;
        s.b  = b;
        return s;
    endfunction

    function automatic stim_t fs_stim();
        stim_t s;
        s    = '0;
        s.fs = 1'b1;
        return s;
    endfunction

    // One cycle: sample outputs, form expectations, drive new inputs, advance model.
    task automatic step(input stim_t s, output obs_t got, output obs_t exp);
        bit h;
        got = {bus.out_valid, bus.color_index, bus.is_b, bus.layer_sel, bus.a_flash, bus.b_flash};
        exp    = pipe[1];
        exp.af = act[0];
        exp.bf = act[1];
        bus.pix_valid   = s.pv;
        bus.blank       = s.blank;
        bus.frame_start = s.fs;
        bus.bg_idx      = s.bg;
        bus.a_idx       = s.a;
        bus.b_idx       = s.b;
        bus.a_hit       = s.ah;
        bus.b_hit       = s.bh;
        pipe[1] = pipe[0];
        pipe[0] = model_arb(s, white_of(0), white_of(1));
        for (int p = 0; p < 2; p++) begin
            h = (p == 0) ? s.ah : s.bh;
            if (h) begin
                act[p]    = 1;
                frames[p] = 0;
            end else if (act[p] && s.fs) begin
                frames[p]++;
                if (frames[p] >= FF) act[p] = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_model();
        pipe[0] = '0;
        pipe[1] = '0;
        for (int p = 0; p < 2; p++) begin
            act[p]    = 0;
            frames[p] = 0;
        end
    endtask

    task automatic test_reset();
        obs_t got;
        rst_n = 1'b0;
        bus.pix_valid = 0; bus.blank = 0; bus.frame_start = 0;
        bus.bg_idx = 0; bus.a_idx = 0; bus.b_idx = 0; bus.a_hit = 0; bus.b_hit = 0;
        clear_model();
        repeat (3) @(negedge clk);
        got = {bus.out_valid, bus.color_index, bus.is_b, bus.layer_sel, bus.a_flash, bus.b_flash};
        n_checks++;
        if (got !== '0) begin
            n_fails++;
            $display("FAIL reset_state: got %b required %b", got, 10'b0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_arbitration();
        obs_t got, exp;
        int   tbl [4][6] = '{'{5, 1, 2, 2, 1, 3}, '{5, 1, 0, 1, 0, 2},
                             '{0, 0, 0, FILL, 0, 0}, '{5, 0, 0, 5, 0, 1}};
        for (int i = 0; i < 4; i++) begin
            step(pix(4'(tbl[i][0]), 4'(tbl[i][1]), 4'(tbl[i][2])), got, exp);
            step(idle_stim(), got, exp);
            step(idle_stim(), got, exp);
            n_checks++;
            if ({got.v, got.idx, got.isb, got.sel} !==
                {1'b1, 4'(tbl[i][3]), 1'(tbl[i][4]), 2'(tbl[i][5])}) begin
                n_fails++;
                $display("FAIL idle_arb[%0d]: got v%b idx%0d isb%b sel%0d required v1 idx%0d isb%0d sel%0d",
                         i, got.v, got.idx, got.isb, got.sel, tbl[i][3], tbl[i][4], tbl[i][5]);
            end
        end
    endtask

    task automatic test_blank();
        obs_t  got, exp;
        stim_t s;
        for (int i = 0; i < 40; i++) begin
            s       = pix(4'd5, 4'd1, 4'd2);
            s.pv    = 1'($urandom_range(0, 1));
            s.blank = 1'b1;
            step(s, got, exp);
            n_checks++;
            if (got.v !== exp.v || got.af !== exp.af || got.bf !== exp.bf ||
                (exp.v && {got.idx, got.isb, got.sel} !== 7'b0)) begin
                n_fails++;
                $display("FAIL blank[%0d]: got %b required %b (data zero when valid)", i, got, exp);
            end
        end
    endtask

    task automatic test_flash_a();
        obs_t got, exp;
        step({3'b000, 12'h000, 2'b10}, got, exp);
        for (int k = 0; k < 34; k++) begin
            if (k > 0) step(fs_stim(), got, exp);
            for (int j = 0; j < 5; j++) begin
                step((j < 3) ? pix(4'd5, 4'd1, 4'd0) : idle_stim(), got, exp);
                n_checks++;
                if (got.v !== exp.v || got.af !== exp.af || got.bf !== exp.bf ||
                    (exp.v && {got.idx, got.isb, got.sel} !== {exp.idx, exp.isb, exp.sel})) begin
                    n_fails++;
                    $display("FAIL flash_a model k%0d j%0d: got %b required %b", k, j, got, exp);
                end
            end
            n_checks++;
            if (got.v !== 1'b1 || got.idx !== ((((k / BP) % 2) == 0 && k < FF) ? 4'(WI) : 4'd1)) begin
                n_fails++;
                $display("FAIL flash_a frame %0d: got v%b idx%0d", k, got.v, got.idx);
            end
        end
    endtask

    task automatic test_flash_b_nobox();
        obs_t  got, exp;
        stim_t s;
        s    = '0;
        s.bh = 1'b1;
        step(s, got, exp);
        step(pix(4'd3, 4'd0, 4'd2), got, exp);
        step(pix(4'd3, 4'd0, 4'd0), got, exp);
        step(idle_stim(), got, exp);
        n_checks++;
        if ({got.v, got.idx, got.isb, got.sel, got.bf} !== {1'b1, 4'(WI), 1'b0, 2'd3, 1'b1}) begin
            n_fails++;
            $display("FAIL b_white: got %b required idx%0d isb0 sel3 bflash1", got, WI);
        end
        step(idle_stim(), got, exp);
        n_checks++;
        if ({got.v, got.idx, got.isb, got.sel} !== {1'b1, 4'd3, 1'b0, 2'd1}) begin
            n_fails++;
            $display("FAIL b_nobox: got %b required idx3 isb0 sel1", got);
        end
        for (int i = 0; i < 200; i++) begin
            s    = pix(4'd3, 4'd0, ($urandom_range(0, 1) != 0) ? 4'd2 : 4'd0);
            s.fs = ($urandom_range(0, 3) == 0);
            step(s, got, exp);
            n_checks++;
            if (got.v !== exp.v || got.af !== exp.af || got.bf !== exp.bf ||
                (exp.v && {got.idx, got.isb, got.sel} !== {exp.idx, exp.isb, exp.sel})) begin
                n_fails++;
                $display("FAIL flash_b model %0d: got %b required %b", i, got, exp);
            end
        end
    endtask

    task automatic test_hit_restart();
        obs_t  got, exp;
        stim_t s;
        s    = '0;
        s.ah = 1'b1;
        step(s, got, exp);
        repeat (FF - 3) step(fs_stim(), got, exp);
        s.fs = 1'b1;
        step(s, got, exp);
        step(pix(4'd5, 4'd1, 4'd0), got, exp);
        step(idle_stim(), got, exp);
        step(idle_stim(), got, exp);
        n_checks++;
        if ({got.v, got.idx, got.sel} !== {1'b1, 4'(WI), 2'd2}) begin
            n_fails++;
            $display("FAIL restart_white: got v%b idx%0d sel%0d required idx%0d sel2", got.v, got.idx, got.sel, WI);
        end
        for (int i = 1; i <= FF; i++) begin
            step(fs_stim(), got, exp);
            n_checks++;
            if (got.af !== 1'b1) begin
                n_fails++;
                $display("FAIL restart_len before fs %0d: a_flash %b required 1", i, got.af);
            end
        end
        step(idle_stim(), got, exp);
        n_checks++;
        if (got.af !== 1'b0) begin
            n_fails++;
            $display("FAIL restart_end: a_flash %b required 0", got.af);
        end
    endtask

    task automatic test_random();
        obs_t  got, exp;
        stim_t s;
        for (int i = 0; i < 3000; i++) begin
            s.pv    = ($urandom_range(0, 3) != 0);
            s.blank = ($urandom_range(0, 9) == 0);
            s.fs    = ($urandom_range(0, 7) == 0);
            s.bg    = ($urandom_range(0, 4) < 2) ? 4'd0 : 4'($urandom);
            s.a     = ($urandom_range(0, 4) < 2) ? 4'd0 : 4'($urandom);
            s.b     = ($urandom_range(0, 4) < 2) ? 4'd0 : 4'($urandom);
            s.ah    = ($urandom_range(0, 199) == 0);
            s.bh    = ($urandom_range(0, 199) == 0);
            step(s, got, exp);
            n_checks++;
            if (got.v !== exp.v || got.af !== exp.af || got.bf !== exp.bf ||
                (exp.v && {got.idx, got.isb, got.sel} !== {exp.idx, exp.isb, exp.sel})) begin
                n_fails++;
                $display("FAIL random %0d: got %b required %b", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_midflash();
        obs_t  got, exp;
        stim_t s;
        s    = '0;
        s.ah = 1'b1;
        step(s, got, exp);
        repeat (3) step(fs_stim(), got, exp);
        step(pix(4'd5, 4'd1, 4'd2), got, exp);
        step(pix(4'd5, 4'd1, 4'd0), got, exp);
        #2 rst_n = 1'b0;
        #1;
        got = {bus.out_valid, bus.color_index, bus.is_b, bus.layer_sel, bus.a_flash, bus.b_flash};
        n_checks++;
        if (got !== '0) begin
            n_fails++;
            $display("FAIL async_reset: got %b required %b", got, 10'b0);
        end
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(pix(4'd5, 4'd1, 4'd0), got, exp);
            n_checks++;
            if (got.v !== (i >= 2) || got.af !== 1'b0 ||
                (exp.v && {got.idx, got.isb, got.sel} !== {exp.idx, exp.isb, exp.sel})) begin
                n_fails++;
                $display("FAIL post_reset %0d: got %b required v%0d af0 data %b", i, got, (i >= 2), exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_arbitration();
        test_blank();
        test_flash_a();
        test_flash_b_nobox();
        test_hit_restart();
        test_random();
        test_reset_midflash();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
